// File: rtl/count_monitor.sv
// Monitors a free-running up-counter: acquires lock after LOCK_LEN consecutive
// +1 steps, then flags sequence breaks (err) and clean wraps (wrap) with tallies.
module count_monitor #(
  parameter int N        = 2,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     cnt_in,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       prev_q, prev_d;
  logic [3:0]         run_q, run_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [ERR_W-1:0]   wrap_count_q, wrap_count_d;

  logic [N-1:0]       prev_inc;
  logic [3:0]         run_inc;
  logic               match;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  // Expected next value wraps naturally in N bits, so 2^N-1 -> 0 is a match.
  assign prev_inc = prev_q + N'(1);
  assign run_inc  = run_q + 4'd1;
  assign match    = (cnt_in == prev_inc);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    if (en) begin
      prev_d = cnt_in;
      unique case (state_q)
        ST_EMPTY: begin
          run_d   = 4'd0;
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == 4'(LOCK_LEN)) state_d = ST_LOCK;
          end else begin
            run_d = 4'd0;
          end
        end
        ST_LOCK: begin
          if (match) begin
            if (cnt_in == '0) begin
              wrap_d       = 1'b1;
              wrap_count_d = wrap_count_q + ERR_W'(1);
            end
          end else begin
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
            run_d       = 4'd0;
            state_d     = ST_ACQ;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      prev_q       <= '0;
      run_q        <= 4'd0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed vector table, corner-case sequences and
// randomized samples against an arithmetic reference model.
module tb_count_monitor;
  localparam int N        = 2;
  localparam int LOCK_LEN = 4;
  localparam int ERR_W    = 8;
  localparam int MODN     = 1 << N;
  localparam int MODE     = 1 << ERR_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [N-1:0]     cnt_in = '0;
  logic             locked, err, wrap;
  logic [ERR_W-1:0] err_count, wrap_count;

  int tests = 0;
  int failed = 0;

  // Reference model state
  bit m_have, m_lock, m_err, m_wrap;
  int m_prev, m_run, m_ec, m_wc;

  count_monitor #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
    .locked(locked), .err(err), .wrap(wrap),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r; bit e; int c;
    bit l; bit er; bit w; int ec; int wc;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input int c);
    if (r) begin
      m_have = 0; m_lock = 0; m_err = 0; m_wrap = 0;
      m_prev = 0; m_run = 0; m_ec = 0; m_wc = 0;
    end else begin
      m_err = 0; m_wrap = 0;
      if (e) begin
        if (!m_have) begin
          m_have = 1; m_run = 0;
        end else if (m_lock) begin
          if (c == (m_prev + 1) % MODN) begin
            if (c == 0) begin m_wrap = 1; m_wc = (m_wc + 1) % MODE; end
          end else begin
            m_err = 1; m_lock = 0; m_run = 0;
            if (m_ec < MODE - 1) m_ec++;
          end
        end else begin
          if (c == (m_prev + 1) % MODN) begin
            m_run++;
            if (m_run == LOCK_LEN) m_lock = 1;
          end else m_run = 0;
        end
        m_prev = c;
      end
    end
  endtask

  // Drive one edge, advance the model, compare every output against it.
  task automatic step(input bit r, input bit e, input int c, input string tag);
    rst = r; en = e; cnt_in = N'(c);
    @(posedge clk);
    #1;
    model(r, e, c);
    chk({tag, ".locked"}, int'(locked), int'(m_lock));
    chk({tag, ".err"}, int'(err), int'(m_err));
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    chk({tag, ".err_count"}, int'(err_count), m_ec);
    chk({tag, ".wrap_count"}, int'(wrap_count), m_wc);
    if (err && wrap) chk({tag, ".err_and_wrap"}, 1, 0);
  endtask

  task automatic lock_from_reset();
    step(1, 0, 0, "lk");
    for (int i = 0; i < 5; i++) step(0, 1, i % MODN, "lk");
  endtask

  initial begin
    int c, nx;
    // rst, en, cnt | locked, err, wrap, err_count, wrap_count
    vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 2, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 3, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 2, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 3, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 1, 0, 1, 0, 1});
    vt.push_back('{0, 1, 1, 1, 0, 0, 0, 1});
    vt.push_back('{0, 1, 3, 0, 1, 0, 1, 1});
    vt.push_back('{0, 1, 0, 0, 0, 0, 1, 1});
    vt.push_back('{0, 1, 1, 0, 0, 0, 1, 1});
    vt.push_back('{0, 1, 2, 0, 0, 0, 1, 1});
    vt.push_back('{0, 1, 3, 1, 0, 0, 1, 1});
    vt.push_back('{0, 1, 0, 1, 0, 1, 1, 2});
    vt.push_back('{0, 1, 0, 0, 1, 0, 2, 2});
    vt.push_back('{0, 0, 2, 0, 0, 0, 2, 2});
    vt.push_back('{0, 1, 1, 0, 0, 0, 2, 2});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].e, vt[i].c, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.locked", i), int'(locked), int'(vt[i].l));
      chk($sformatf("tbl%0d.err", i), int'(err), int'(vt[i].er));
      chk($sformatf("tbl%0d.wrap", i), int'(wrap), int'(vt[i].w));
      chk($sformatf("tbl%0d.err_count", i), int'(err_count), vt[i].ec);
      chk($sformatf("tbl%0d.wrap_count", i), int'(wrap_count), vt[i].wc);
    end

    // Gap: en=0 for 5 cycles mid-acquisition must not disturb anything.
    step(1, 0, 0, "gap");
    step(0, 1, 0, "gap"); step(0, 1, 1, "gap"); step(0, 1, 2, "gap");
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, MODN - 1), "gap_idle");
    step(0, 1, 3, "gap");
    chk("gap.not_yet_locked", int'(locked), 0);
    step(0, 1, 0, "gap");
    chk("gap.locked", int'(locked), 1);
    chk("gap.no_wrap_on_lock", int'(wrap), 0);

    // Reset while locked with err_count=3.
    lock_from_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, "rm_brk");
      for (int i = 1; i <= 4; i++) step(0, 1, i % MODN, "rm_relock");
    end
    chk("rm.err_count3", int'(err_count), 3);
    chk("rm.locked_before", int'(locked), 1);
    step(1, 1, 2, "rm_rst");
    chk("rm.locked0", int'(locked), 0);
    chk("rm.err_count0", int'(err_count), 0);
    chk("rm.wrap_count0", int'(wrap_count), 0);
    step(0, 1, 2, "rm_first");
    step(0, 1, 0, "rm_second");
    chk("rm.no_err_in_acq", int'(err), 0);

    // Saturation: 300 break/relock rounds, each with one wrap and one err.
    lock_from_reset();
    for (int k = 0; k < 300; k++) begin
      for (int i = 1; i <= 4; i++) step(0, 1, i % MODN, "sat_wrap");
      step(0, 1, 0, "sat_brk");
      for (int i = 1; i <= 4; i++) step(0, 1, i % MODN, "sat_relock");
    end
    chk("sat.err_count", int'(err_count), 255);
    chk("sat.wrap_count", int'(wrap_count), 300 % 256);

    // Randomized samples, mostly well-behaved with occasional breaks and resets.
    step(1, 0, 0, "rnd");
    for (int i = 0; i < 2000; i++) begin
      nx = (m_prev + 1) % MODN;
      c = ($urandom_range(0, 7) != 0) ? nx : int'($urandom_range(0, MODN - 1));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, c, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
